// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_unit: PC, instruction-memory req/ack fetch, opcode classification |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [2:0]  instr_type,
    output logic [31:0] pc_out
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] VALID = 1'b1;

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;
    localparam logic [2:0] TYPE_N = 3'd7;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] pc_out_q, pc_out_d;

    function automatic logic [2:0] decode_type(input logic [6:0] opcode);
        logic [2:0] t;
        case (opcode)
            7'b0110011:                                     t = TYPE_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: t = TYPE_I;
            7'b0100011:                                     t = TYPE_S;
            7'b1100011:                                     t = TYPE_B;
            7'b0110111, 7'b0010111:                         t = TYPE_U;
            7'b1101111:                                     t = TYPE_J;
            default:                                        t = TYPE_N;
        endcase
        return t;
    endfunction

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        type_d   = type_q;
        pc_out_d = pc_out_q;
        // Redirect wins over both a pending ack and a downstream handshake.
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~32'h3;
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (mem_ack) begin
                instr_d  = mem_rdata;
                type_d   = decode_type(mem_rdata[6:0]);
                pc_out_d = pc_q;
                pc_d     = pc_q + 32'd4;
                state_d  = VALID;
            end
        end else if (out_ready) begin
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            type_q   <= TYPE_I;
            pc_out_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            type_q   <= type_d;
            pc_out_q <= pc_out_d;
        end
    end

    // Request is held low while reset is asserted even though state is FETCH.
    assign mem_req    = rst_n & (state_q == FETCH);
    assign mem_addr   = pc_q;
    assign out_valid  = (state_q == VALID);
    assign instr      = instr_q;
    assign instr_type = type_q;
    assign pc_out     = pc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fetch_unit: directed + randomized bench with a behavioural model     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  instr_type;
    logic [31:0] pc_out;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instr          (instr),
        .instr_type     (instr_type),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    // Opcode -> type lookup table.
    logic [2:0] lut [0:127];
    initial begin
        for (int i = 0; i < 128; i++) lut[i] = 3'd7;
        lut[7'b0110011] = 3'd0;
        lut[7'b0010011] = 3'd1;
        lut[7'b0000011] = 3'd1;
        lut[7'b1100111] = 3'd1;
        lut[7'b1110011] = 3'd1;
        lut[7'b0100011] = 3'd2;
        lut[7'b1100011] = 3'd3;
        lut[7'b0110111] = 3'd4;
        lut[7'b0010111] = 3'd4;
        lut[7'b1101111] = 3'd5;
    end

    // Model: "holding" means a fetched word awaits downstream acceptance.
    bit          m_holding = 1'b0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_instr   = 32'h0000_0013;
    logic [2:0]  m_type    = 3'd1;
    logic [31:0] m_pc_out  = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_holding = 1'b0;
            m_pc      = 32'h0;
            m_instr   = 32'h0000_0013;
            m_type    = 3'd1;
            m_pc_out  = 32'h0;
        end else if (redirect_valid) begin
            m_pc      = {redirect_pc[31:2], 2'b00};
            m_holding = 1'b0;
        end else if (!m_holding) begin
            if (mem_ack) begin
                m_instr   = mem_rdata;
                m_type    = lut[mem_rdata[6:0]];
                m_pc_out  = m_pc;
                m_pc      = m_pc + 32'd4;
                m_holding = 1'b1;
            end
        end else if (out_ready) begin
            m_holding = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    bit done = 1'b0;
    always @(negedge clk) begin
        if (!done) begin
            chk("m.mem_req",   {31'b0, mem_req},    {31'b0, (rst_n === 1'b1) && !m_holding});
            chk("m.mem_addr",  mem_addr,            m_pc);
            chk("m.out_valid", {31'b0, out_valid},  {31'b0, m_holding});
            chk("m.instr",     instr,               m_instr);
            chk("m.type",      {29'b0, instr_type}, {29'b0, m_type});
            chk("m.pc_out",    pc_out,              m_pc_out);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic ack, input logic [31:0] rd, input logic rdy,
                       input logic redir, input logic [31:0] rpc);
        mem_ack        = ack;
        mem_rdata      = rd;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    logic [6:0]  sweep_op  [0:5] = '{7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000};
    logic [2:0]  sweep_exp [0:5] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd1, 3'd7};
    logic [6:0]  rand_op   [0:13] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                                      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                      7'b0000000, 7'b1111111, 7'b0001111, 7'b1010101};

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) cyc();
        chk("rst.mem_req",   {31'b0, mem_req},    32'd0);
        chk("rst.out_valid", {31'b0, out_valid},  32'd0);
        chk("rst.instr",     instr,               32'h0000_0013);
        chk("rst.type",      {29'b0, instr_type}, 32'd1);
        chk("rst.pc_out",    pc_out,              32'd0);
        rst_n = 1'b1;
        #1;
        chk("c1.mem_req",  {31'b0, mem_req}, 32'd1);
        chk("c1.mem_addr", mem_addr,         32'h0);

        // Zero-wait fetch of a NOP at 0x0.
        drv(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        cyc();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t1.out_valid", {31'b0, out_valid},  32'd1);
        chk("t1.type",      {29'b0, instr_type}, 32'd1);
        chk("t1.pc_out",    pc_out,              32'h0);
        chk("t1.mem_addr",  mem_addr,            32'h4);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t1.next_req",  {31'b0, mem_req}, 32'd1);
        chk("t1.next_addr", mem_addr,         32'h4);

        // Three wait cycles, then an add.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2.wait_valid", {31'b0, out_valid}, 32'd0);
        end
        drv(1'b1, 32'h0020_8033, 1'b0, 1'b0, 32'h0);
        cyc();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("t2.type",   {29'b0, instr_type}, 32'd0);
        chk("t2.pc_out", pc_out,              32'h4);
        cyc();

        // Back-pressure on a jal; stray acks while held must be ignored.
        drv(1'b1, 32'h0000_006F, 1'b0, 1'b0, 32'h0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
            chk("t3.valid",   {31'b0, out_valid},  32'd1);
            chk("t3.instr",   instr,               32'h0000_006F);
            chk("t3.type",    {29'b0, instr_type}, 32'd5);
            chk("t3.pc_out",  pc_out,              32'h8);
            chk("t3.mem_req", {31'b0, mem_req},    32'd0);
            cyc();
        end
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc();
        out_ready = 1'b0;
        chk("t3.resume_addr", mem_addr,         32'hC);
        chk("t3.resume_req",  {31'b0, mem_req}, 32'd1);

        // Redirect colliding with an ack: the ack is dropped.
        drv(1'b1, 32'h0000_0013, 1'b0, 1'b1, 32'h0000_0102);
        cyc();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t4.valid",    {31'b0, out_valid}, 32'd0);
        chk("t4.mem_addr", mem_addr,           32'h100);
        chk("t4.instr",    instr,              32'h0000_006F);
        chk("t4.pc_out",   pc_out,             32'h8);
        cyc();
        chk("t4.still_idle", {31'b0, out_valid}, 32'd0);
        drv(1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
        cyc();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t4.valid_after", {31'b0, out_valid}, 32'd1);
        chk("t4.pc_out_new",  pc_out,             32'h100);

        // Opcode sweep.
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            cyc();
            r = $urandom;
            drv(1'b1, {r[31:7], sweep_op[i]}, 1'b0, 1'b0, 32'h0);
            cyc();
            drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("t5.sweep_type", {29'b0, instr_type}, {29'b0, sweep_exp[i]});
        end

        // PC wrap at the top of the address space.
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        cyc();
        drv(1'b1, 32'h0000_0017, 1'b0, 1'b0, 32'h0);
        chk("t6.top_addr", mem_addr, 32'hFFFF_FFFC);
        cyc();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("t6.pc_out", pc_out,              32'hFFFF_FFFC);
        chk("t6.type",   {29'b0, instr_type}, 32'd4);
        cyc();
        out_ready = 1'b0;
        chk("t6.wrap_addr", mem_addr, 32'h0);

        // Asynchronous reset while holding a valid instruction.
        drv(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        cyc();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t7.valid_before", {31'b0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t7.async_valid", {31'b0, out_valid}, 32'd0);
        chk("t7.async_req",   {31'b0, mem_req},   32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t7.restart_req",  {31'b0, mem_req}, 32'd1);
        chk("t7.restart_addr", mem_addr,         32'h0);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            drv(($urandom_range(0, 99) < 50), {r[31:7], rand_op[$urandom_range(0, 13)]},
                ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 6), $urandom);
            cyc();
        end

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the immediate builder and decode logic in the TP2 RISC-V core.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and classifies it into the shared 3-bit instruction-type code.
- Presents instr, instr_type and pc to the downstream stage over a valid/ready handshake; accepts branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_req  output  1  instruction memory read request.
- mem_addr  output  32  word-aligned read address (equals current PC).
- mem_ack  input  1  memory response valid; mem_rdata is valid in the same cycle.
- mem_rdata  input  32  instruction word from memory.
- redirect_valid  input  1  one-cycle pulse: load PC from redirect_pc.
- redirect_pc  input  32  new fetch address (bits [1:0] ignored).
- out_valid  output  1  instr/instr_type/pc_out are valid.
- out_ready  input  1  downstream accepts the current instruction.
- instr  output  32  latched instruction word.
- instr_type  output  3  type code: R=0, I=1, S=2, B=3, U=4, J=5, N=7; 6 is never produced.
- pc_out  output  32  address the latched instruction was fetched from.

Behaviour:
- Reset (async, rst_n=0):
  - pc<=RESET_PC, state<=FETCH, out_valid=0, instr=32'h0000_0013 (NOP), instr_type=I (1), pc_out=0.
  - mem_req is 0 while reset is asserted and goes to 1 in the first cycle after release.
- States: FETCH, VALID.
- FETCH:
  - mem_req=1, mem_addr=pc, out_valid=0.
  - On mem_ack (same cycle or any later cycle) with no redirect: instr<=mem_rdata, instr_type<=decode(mem_rdata[6:0]), pc_out<=pc, pc<=pc+4, go to VALID.
- VALID:
  - mem_req=0, out_valid=1; outputs are stable until accepted.
  - On out_ready with no redirect: go to FETCH.
  - Throughput with zero-wait memory is 1 instruction per 2 cycles.
  - Latency: ack in cycle N gives out_valid=1 in cycle N+1.
- Redirect (highest priority, either state):
  - pc<=redirect_pc & ~32'h3, state<=FETCH, out_valid<=0 next cycle.
  - A mem_ack in the same cycle is discarded; instr and pc_out keep their old values.
  - A simultaneous out_ready handshake counts as accepted downstream.
- Decode of mem_rdata[6:0]:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - All other values -> N (7).
- Arithmetic: pc+4 is a 32-bit modulo add; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- mem_ack outside FETCH is ignored.
- mem_addr always equals pc; in VALID it already shows the next address.

Test Plan:
- Reset then zero-wait memory returning 32'h0000_0013 at 0x0 -> mem_req=1 and mem_addr=0 in cycle 1; out_valid=1 in cycle 2 with instr_type=1 and pc_out=0; the next fetch is at 0x4.
- Memory with 3 wait cycles returning 32'h00208033 (add) -> out_valid stays 0 for 3 cycles; then instr_type=0 and pc_out equals the request address.
- Back-pressure: out_ready=0 for 5 cycles with 32'h0000006F (jal) latched -> out_valid, instr, instr_type=5 and pc_out are held stable; mem_req=0 throughout; after out_ready=1, FETCH resumes at pc_out+4.
- Redirect to 32'h0000_0102 in the same cycle as mem_ack -> the acked data is dropped, the next mem_addr is 0x100, and out_valid stays 0 until the 0x100 data arrives.
- Type sweep with opcodes 0100011, 1100011, 0110111, 0010111, 1100111 and 0000000 -> instr_type = 2, 3, 4, 4, 1, 7 respectively.
- Wrap and mid-operation reset:
  - Redirect to 0xFFFF_FFFC, then accept -> the next fetch is at 0x0.
  - rst_n pulsed low while in VALID -> out_valid drops immediately (async), and after release fetch restarts at RESET_PC.
